// File: rtl/bram_dma_engine.sv
// Block copy / block fill bus master for port A of the lower-RAM block RAM.
// Copy moves one byte per RD/CAP/WR triple; fill writes one byte per cycle.
module bram_dma_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_dir,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_fill_val,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_di,
    input  logic [DATA_W-1:0] i_mem_do,
    input  logic              i_mem_dr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [LEN_W-1:0]  o_remaining
);

    // state   | meaning
    // IDLE    | no command; accepts start
    // WAITRDY | command latched, waiting for RAM data-ready
    // RD      | present source address for read
    // CAP     | read data valid; captured into hold
    // WR      | write hold to destination, advance pointers
    // FILL    | write fill byte to destination, advance pointer
    typedef enum logic [2:0] {
        S_IDLE, S_WAITRDY, S_RD, S_CAP, S_WR, S_FILL
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  L_ONE = LEN_W'(1);

    state_t              r_state;
    logic                r_mode;
    logic                r_dir;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_rem;
    logic [DATA_W-1:0]   r_fill;
    logic [DATA_W-1:0]   r_hold;
    logic                r_done;
    logic                r_aborted;

    logic [ADDR_W-1:0]   w_src_nxt;
    logic [ADDR_W-1:0]   w_dst_nxt;
    logic                w_last;

    assign w_src_nxt = r_dir ? (r_src - A_ONE) : (r_src + A_ONE);
    assign w_dst_nxt = r_dir ? (r_dst - A_ONE) : (r_dst + A_ONE);
    assign w_last    = (r_rem == L_ONE);

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_aborted   = r_aborted;
    assign o_remaining = r_rem;

    always_comb begin
        o_mem_addr = '0;
        o_mem_we   = 1'b0;
        o_mem_di   = '0;
        case (r_state)
            S_RD, S_CAP: o_mem_addr = r_src;
            S_WR: begin
                o_mem_addr = r_dst;
                o_mem_we   = 1'b1;
                o_mem_di   = r_hold;
            end
            S_FILL: begin
                o_mem_addr = r_dst;
                o_mem_we   = 1'b1;
                o_mem_di   = r_fill;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_dir     <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_fill    <= '0;
            r_hold    <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode    <= i_mode;
                        r_dir     <= i_dir;
                        r_src     <= i_src;
                        r_dst     <= i_dst;
                        r_rem     <= i_len;
                        r_fill    <= i_fill_val;
                        r_aborted <= 1'b0;
                        if (i_len == '0)
                            r_done <= 1'b1;
                        else if (!i_mem_dr)
                            r_state <= S_WAITRDY;
                        else
                            r_state <= i_mode ? S_FILL : S_RD;
                    end
                end
                S_WAITRDY: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (i_mem_dr) begin
                        r_state <= r_mode ? S_FILL : S_RD;
                    end
                end
                S_RD, S_CAP: begin
                    if (r_state == S_CAP)
                        r_hold <= i_mem_do;
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= (r_state == S_RD) ? S_CAP : S_WR;
                    end
                end
                S_WR, S_FILL: begin
                    // The write presented this cycle lands even if abort is high.
                    if (r_state == S_WR)
                        r_src <= w_src_nxt;
                    r_dst <= w_dst_nxt;
                    r_rem <= r_rem - L_ONE;
                    if (i_abort || w_last) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_aborted <= i_abort;
                    end else begin
                        r_state <= (r_state == S_WR) ? S_RD : S_FILL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_dma_engine.sv
// Bench for bram_dma_engine: behavioural RAM plus a byte-level memory model
// that replays copy/fill as sequential per-byte moves.
module tb_bram_dma_engine;

    logic        clka = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_mode = 1'b0, i_dir = 1'b0, i_abort = 1'b0;
    logic [15:0] i_src = '0, i_dst = '0, i_len = '0;
    logic [7:0]  i_fill_val = '0;
    logic [15:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_di;
    logic [7:0]  i_mem_do;
    logic        i_mem_dr = 1'b1;
    logic        o_busy, o_done, o_aborted;
    logic [15:0] o_remaining;

    always #5 clka = ~clka;

    bram_dma_engine #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) dut (
        .clka(clka), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_dir(i_dir),
        .i_src(i_src), .i_dst(i_dst), .i_len(i_len), .i_fill_val(i_fill_val),
        .i_abort(i_abort), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
        .o_mem_di(o_mem_di), .i_mem_do(i_mem_do), .i_mem_dr(i_mem_dr),
        .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
        .o_remaining(o_remaining)
    );

    logic [7:0]  ram  [0:65535];
    logic [7:0]  expm [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clka) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (o_mem_we) ram[o_mem_addr] <= o_mem_di;
        i_mem_do <= ram[o_mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;
    int bc, wc, dc, lat;
    logic [15:0] la [0:511];
    logic [7:0]  ld [0:511];

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clka);
        pre_we = 1'b1; pre_addr = a; pre_data = d; expm[a] = d;
        @(negedge clka);
        pre_we = 1'b0;
    endtask

    task automatic model_copy(input logic d, input logic [15:0] s, input logic [15:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] sa, ta;
            sa = d ? s - 16'(i) : s + 16'(i);
            ta = d ? t - 16'(i) : t + 16'(i);
            expm[ta] = expm[sa];
        end
    endtask

    task automatic model_fill(input logic d, input logic [15:0] t, input int n, input logic [7:0] f);
        for (int i = 0; i < n; i++) begin
            logic [15:0] ta;
            ta = d ? t - 16'(i) : t + 16'(i);
            expm[ta] = f;
        end
    endtask

    task automatic cmp_window(input logic [15:0] base, input int lo, input int hi, input string tag);
        for (int k = lo; k <= hi; k++) begin
            logic [15:0] a;
            a = base + 16'(k);
            vectors++;
            if (ram[a] !== expm[a]) begin
                miscompares++;
                $display("FAIL %s mem[%h]: got %h expected %h", tag, a, ram[a], expm[a]);
            end
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [15:0] s, input logic [15:0] t,
                         input logic [15:0] n, input logic [7:0] f);
        @(negedge clka);
        i_mode = m; i_dir = d; i_src = s; i_dst = t; i_len = n; i_fill_val = f; i_start = 1'b1;
    endtask

    // Samples each cycle at the falling edge until done; optional abort/start injection
    // in the given busy cycle (1-based).
    task automatic wait_done(input int budget, input int abort_at, input int start_at,
                             input logic [15:0] alt_dst);
        logic seen;
        seen = 1'b0; bc = 0; wc = 0; dc = 0; lat = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clka);
            i_start = 1'b0; i_abort = 1'b0;
            if (o_busy) bc++;
            if (o_mem_we) begin
                if (wc < 512) begin la[wc] = o_mem_addr; ld[wc] = o_mem_di; end
                wc++;
            end
            if (o_done) begin dc++; lat = cyc + 1; seen = 1'b1; break; end
            if (o_busy && bc == abort_at) i_abort = 1'b1;
            if (o_busy && bc == start_at) begin i_start = 1'b1; i_dst = alt_dst; end
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done timeout: got no done within %0d cycles, expected done", budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clka);
        vectors += 7;
        if (o_busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        if (o_done !== 1'b0)        begin miscompares++; $display("FAIL reset_done: got %b expected 0", o_done); end
        if (o_aborted !== 1'b0)     begin miscompares++; $display("FAIL reset_aborted: got %b expected 0", o_aborted); end
        if (o_remaining !== 16'h0)  begin miscompares++; $display("FAIL reset_remaining: got %h expected 0", o_remaining); end
        if (o_mem_we !== 1'b0)      begin miscompares++; $display("FAIL reset_we: got %b expected 0", o_mem_we); end
        if (o_mem_addr !== 16'h0)   begin miscompares++; $display("FAIL reset_addr: got %h expected 0", o_mem_addr); end
        if (o_mem_di !== 8'h0)      begin miscompares++; $display("FAIL reset_di: got %h expected 0", o_mem_di); end
        rst = 1'b0;
    endtask

    task automatic test_copy_basic;
        logic [7:0] pat [0:3];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), pat[i]);
        for (int i = -1; i <= 4; i++) preload(16'h0200 + 16'(i), 8'h00);
        issue(1'b0, 1'b0, 16'h0100, 16'h0200, 16'd4, 8'h00);
        wait_done(40, 0, 0, 16'h0);
        vectors += 4;
        if (bc !== 12) begin miscompares++; $display("FAIL copy_busy: got %0d expected 12", bc); end
        if (wc !== 4)  begin miscompares++; $display("FAIL copy_writes: got %0d expected 4", wc); end
        if (o_remaining !== 16'h0) begin miscompares++; $display("FAIL copy_remaining: got %0d expected 0", o_remaining); end
        if (o_aborted !== 1'b0) begin miscompares++; $display("FAIL copy_aborted: got %b expected 0", o_aborted); end
        for (int i = 0; i < 4; i++) begin
            vectors += 2;
            if (la[i] !== 16'h0200 + 16'(i)) begin miscompares++; $display("FAIL copy_addr%0d: got %h expected %h", i, la[i], 16'h0200 + 16'(i)); end
            if (ld[i] !== pat[i]) begin miscompares++; $display("FAIL copy_data%0d: got %h expected %h", i, ld[i], pat[i]); end
        end
        @(negedge clka);
        vectors++;
        if (o_done !== 1'b0) begin miscompares++; $display("FAIL copy_done_width: got %b expected 0", o_done); end
        model_copy(1'b0, 16'h0100, 16'h0200, 4);
        cmp_window(16'h0200, -1, 4, "copy_mem");
    endtask

    task automatic test_fill_wrap;
        for (int i = -1; i <= 3; i++) preload(16'hFFFE + 16'(i), 8'h5A);
        issue(1'b1, 1'b0, 16'h0, 16'hFFFE, 16'd3, 8'hA5);
        wait_done(20, 0, 0, 16'h0);
        vectors += 5;
        if (bc !== 3) begin miscompares++; $display("FAIL fill_busy: got %0d expected 3", bc); end
        if (wc !== 3) begin miscompares++; $display("FAIL fill_writes: got %0d expected 3", wc); end
        if (la[0] !== 16'hFFFE || la[1] !== 16'hFFFF || la[2] !== 16'h0000) begin
            miscompares++; $display("FAIL fill_wrap_addr: got %h %h %h expected fffe ffff 0000", la[0], la[1], la[2]);
        end
        if (ld[2] !== 8'hA5) begin miscompares++; $display("FAIL fill_data: got %h expected a5", ld[2]); end
        if (ram[16'h0001] !== 8'h5A) begin miscompares++; $display("FAIL fill_past_end: got %h expected 5a", ram[16'h0001]); end
        model_fill(1'b0, 16'hFFFE, 3, 8'hA5);
        cmp_window(16'hFFFE, -1, 3, "fill_mem");
    endtask

    task automatic test_overlap;
        preload(16'h000F, 8'hEE);
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) preload(16'h0014 + 16'(i), 8'h00);
        preload(16'h0018, 8'hEE);
        issue(1'b0, 1'b1, 16'h0013, 16'h0017, 16'd4, 8'h00);
        wait_done(40, 0, 0, 16'h0);
        vectors++;
        if (bc !== 12) begin miscompares++; $display("FAIL overlap_busy: got %0d expected 12", bc); end
        for (int i = 0; i < 4; i++) begin
            vectors += 2;
            if (ram[16'h0014 + 16'(i)] !== 8'(i + 1)) begin miscompares++; $display("FAIL overlap_dst%0d: got %h expected %h", i, ram[16'h0014 + 16'(i)], 8'(i + 1)); end
            if (ram[16'h0010 + 16'(i)] !== 8'(i + 1)) begin miscompares++; $display("FAIL overlap_src%0d: got %h expected %h", i, ram[16'h0010 + 16'(i)], 8'(i + 1)); end
        end
        model_copy(1'b1, 16'h0013, 16'h0017, 4);
        cmp_window(16'h0010, -1, 8, "overlap_mem");
    endtask

    task automatic test_len0_and_busy_start;
        for (int i = 0; i < 8; i++) preload(16'h0300 + 16'(i), 8'($urandom));
        for (int i = -1; i <= 8; i++) preload(16'h0400 + 16'(i), 8'h00);
        for (int i = -1; i <= 8; i++) preload(16'h0500 + 16'(i), 8'h00);
        issue(1'b0, 1'b0, 16'h0300, 16'h0400, 16'd0, 8'h00);
        wait_done(5, 0, 0, 16'h0);
        vectors += 3;
        if (bc !== 0 || wc !== 0) begin miscompares++; $display("FAIL len0_activity: got busy %0d writes %0d expected 0 0", bc, wc); end
        if (lat !== 1) begin miscompares++; $display("FAIL len0_done_latency: got %0d expected 1", lat); end
        if (dc !== 1) begin miscompares++; $display("FAIL len0_done: got %0d expected 1", dc); end
        issue(1'b0, 1'b0, 16'h0300, 16'h0400, 16'd8, 8'h00);
        wait_done(60, 0, 4, 16'h0500);
        vectors += 3;
        if (bc !== 24) begin miscompares++; $display("FAIL busystart_busy: got %0d expected 24", bc); end
        if (wc !== 8) begin miscompares++; $display("FAIL busystart_writes: got %0d expected 8", wc); end
        if (la[7] !== 16'h0407) begin miscompares++; $display("FAIL busystart_dst: got %h expected 0407", la[7]); end
        model_copy(1'b0, 16'h0300, 16'h0400, 8);
        cmp_window(16'h0400, -1, 8, "busystart_mem");
        cmp_window(16'h0500, -1, 8, "busystart_alt");
    endtask

    task automatic test_abort;
        for (int i = 0; i < 8; i++) preload(16'h0600 + 16'(i), 8'($urandom));
        for (int i = -1; i <= 8; i++) preload(16'h0700 + 16'(i), 8'h00);
        issue(1'b0, 1'b0, 16'h0600, 16'h0700, 16'd8, 8'h00);
        wait_done(60, 7, 0, 16'h0);
        vectors += 5;
        if (wc !== 2) begin miscompares++; $display("FAIL abort_writes: got %0d expected 2", wc); end
        if (bc !== 7) begin miscompares++; $display("FAIL abort_busy: got %0d expected 7", bc); end
        if (dc !== 1) begin miscompares++; $display("FAIL abort_done: got %0d expected 1", dc); end
        if (o_aborted !== 1'b1) begin miscompares++; $display("FAIL abort_flag: got %b expected 1", o_aborted); end
        if (o_remaining !== 16'd6) begin miscompares++; $display("FAIL abort_remaining: got %0d expected 6", o_remaining); end
        model_copy(1'b0, 16'h0600, 16'h0700, 2);
        cmp_window(16'h0700, -1, 8, "abort_mem");
        @(negedge clka);
        i_abort = 1'b1;
        @(negedge clka);
        i_abort = 1'b0;
        vectors++;
        if (o_done !== 1'b0) begin miscompares++; $display("FAIL idle_abort_done: got %b expected 0", o_done); end
        issue(1'b0, 1'b0, 16'h0600, 16'h0700, 16'd0, 8'h00);
        wait_done(5, 0, 0, 16'h0);
        vectors++;
        if (o_aborted !== 1'b0) begin miscompares++; $display("FAIL abort_clear: got %b expected 0", o_aborted); end
    endtask

    task automatic test_rst_waitrdy;
        int n, d, b, w;
        for (int i = -1; i <= 15; i++) preload(16'h0800 + 16'(i), 8'h00);
        issue(1'b1, 1'b0, 16'h0, 16'h0800, 16'd100, 8'h3C);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clka);
            i_start = 1'b0;
            if (o_mem_we) n++;
        end
        rst = 1'b1;
        @(negedge clka);
        rst = 1'b0;
        i_mem_dr = 1'b0;
        vectors += 3;
        if (o_mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b expected 0", o_mem_we); end
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        if (n !== 10) begin miscompares++; $display("FAIL rst_prewrites: got %0d expected 10", n); end
        d = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done) d++;
            @(negedge clka);
        end
        vectors++;
        if (d !== 0) begin miscompares++; $display("FAIL rst_done: got %0d pulses expected 0", d); end
        model_fill(1'b0, 16'h0800, 10, 8'h3C);
        cmp_window(16'h0800, -1, 15, "rst_mem");
        preload(16'h0900, 8'h9A); preload(16'h0901, 8'hBC);
        for (int i = -1; i <= 2; i++) preload(16'h0980 + 16'(i), 8'h00);
        issue(1'b0, 1'b0, 16'h0900, 16'h0980, 16'd2, 8'h00);
        b = 0; w = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clka);
            i_start = 1'b0;
            if (o_busy) b++;
            if (o_mem_we) w++;
        end
        i_mem_dr = 1'b1;
        vectors += 2;
        if (b !== 5) begin miscompares++; $display("FAIL waitrdy_busy: got %0d expected 5", b); end
        if (w !== 0) begin miscompares++; $display("FAIL waitrdy_we: got %0d expected 0", w); end
        wait_done(30, 0, 0, 16'h0);
        vectors += 2;
        if (bc !== 6) begin miscompares++; $display("FAIL waitrdy_copy_busy: got %0d expected 6", bc); end
        if (wc !== 2) begin miscompares++; $display("FAIL waitrdy_copy_writes: got %0d expected 2", wc); end
        model_copy(1'b0, 16'h0900, 16'h0980, 2);
        cmp_window(16'h0980, -1, 2, "waitrdy_mem");
    endtask

    task automatic test_random;
        for (int it = 0; it < 24; it++) begin
            logic m, d;
            logic [15:0] s, t;
            logic [7:0] f;
            int n, ab, ew, eb;
            m = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            s = 16'($urandom);
            t = 16'($urandom);
            f = 8'($urandom);
            n = int'($urandom_range(2, 12));
            ab = 0;
            if ($urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, m ? n - 1 : 3 * n - 1));
            for (int k = -14; k <= 14; k++) preload(s + 16'(k), 8'($urandom));
            for (int k = -14; k <= 14; k++) preload(t + 16'(k), 8'($urandom));
            ew = (ab == 0) ? n : (m ? ab : ab / 3);
            eb = (ab == 0) ? (m ? n : 3 * n) : ab;
            issue(m, d, s, t, 16'(n), f);
            wait_done(3 * n + 10, ab, 0, 16'h0);
            vectors += 5;
            if (bc !== eb) begin miscompares++; $display("FAIL rand%0d_busy: got %0d expected %0d", it, bc, eb); end
            if (wc !== ew) begin miscompares++; $display("FAIL rand%0d_writes: got %0d expected %0d", it, wc, ew); end
            if (dc !== 1) begin miscompares++; $display("FAIL rand%0d_done: got %0d expected 1", it, dc); end
            if (o_remaining !== 16'(n - ew)) begin miscompares++; $display("FAIL rand%0d_remaining: got %0d expected %0d", it, o_remaining, n - ew); end
            if (o_aborted !== (ab != 0)) begin miscompares++; $display("FAIL rand%0d_aborted: got %b expected %b", it, o_aborted, (ab != 0)); end
            if (m) model_fill(d, t, ew, f);
            else   model_copy(d, s, t, ew);
            cmp_window(t, -13, 13, "rand_mem");
        end
    endtask

    initial begin
        test_reset;
        test_copy_basic;
        test_fill_wrap;
        test_overlap;
        test_len0_and_busy_start;
        test_abort;
        test_rst_waitrdy;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
